// File: rtl/mem_access_stage.sv
// MEM stage: word loads/stores over a req/ack data bus, results to MEM_WB.
// Latency 1 for ALU ops, >=2 for memory ops; mem_stall holds EX/MEM while an access is outstanding.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_dest_reg,
    input  logic [1:0]  ex_wb_ctrl,
    input  logic        mem_flush,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] memory_data,
    output logic [31:0] ALU_Output,
    output logic [4:0]  destination_reg,
    output logic [1:0]  control_signals,
    output logic        pwrite4,
    output logic        mem_fault
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic        op_load;
    logic [4:0]  op_dest;
    logic [1:0]  op_ctrl;
    logic        kill;

    logic start, alu_done, bad_req, acc_done, acc_timeout, kill_eff, is_mem, bad;

    assign is_mem   = ex_mem_read | ex_mem_write;
    // Both directions at once is illegal; misalignment only matters for real accesses.
    assign bad      = (ex_mem_read & ex_mem_write) | (ex_alu_out[1:0] != 2'b00);
    assign kill_eff = kill | mem_flush;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        start       = 1'b0;
        alu_done    = 1'b0;
        bad_req     = 1'b0;
        acc_done    = 1'b0;
        acc_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid && !mem_flush) begin
                    if (!is_mem) begin
                        alu_done = 1'b1;
                    end else if (bad) begin
                        bad_req = 1'b1;
                    end else begin
                        start     = 1'b1;
                        state_nxt = ACCESS;
                        cnt_nxt   = '0;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    acc_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    acc_timeout = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign mem_stall = (state == ACCESS);
    assign dmem_req  = (state == ACCESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_load         <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            op_dest         <= '0;
            op_ctrl         <= '0;
            kill            <= 1'b0;
            memory_data     <= '0;
            ALU_Output      <= '0;
            destination_reg <= '0;
            control_signals <= '0;
            pwrite4         <= 1'b0;
            mem_fault       <= 1'b0;
        end else begin
            pwrite4   <= 1'b0;
            mem_fault <= 1'b0;
            if (start) begin
                op_load    <= ex_mem_read;
                dmem_we    <= ex_mem_write;
                dmem_addr  <= ex_alu_out;
                dmem_wdata <= ex_store_data;
                op_dest    <= ex_dest_reg;
                op_ctrl    <= ex_wb_ctrl;
            end
            // A flushed access still finishes on the bus, it just retires silently.
            if (acc_done || acc_timeout) begin
                kill <= 1'b0;
            end else if (state == ACCESS && mem_flush) begin
                kill <= 1'b1;
            end
            if (alu_done) begin
                pwrite4         <= 1'b1;
                memory_data     <= '0;
                ALU_Output      <= ex_alu_out;
                destination_reg <= ex_dest_reg;
                control_signals <= ex_wb_ctrl;
            end
            if (bad_req || (acc_timeout && !kill_eff)) begin
                mem_fault <= 1'b1;
            end
            if (acc_done && !kill_eff) begin
                pwrite4         <= 1'b1;
                memory_data     <= op_load ? dmem_rdata : 32'h0;
                ALU_Output      <= dmem_addr;
                destination_reg <= op_dest;
                control_signals <= op_ctrl;
            end
        end
    end

endmodule
